// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU result widths and the packed tagged-result entry
package alu_pkg;
  localparam int ID_SIZE        = 8;
  localparam int FIFO_OUT_WIDTH = 25;
  localparam int FIFO_OUT_DEPTH = 8;
  localparam int RESULT_W       = FIFO_OUT_WIDTH - ID_SIZE;

  typedef struct packed {
    logic [ID_SIZE-1:0]  id;
    logic [RESULT_W-1:0] result;
  } fifo_entry_t;
endpackage

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - pointers, occupancy, sticky error flags and ready back-pressure
module fifo_ptr_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en_i,
  input  logic              r_en_i,
  output logic              wr_accept_o,
  output logic [ADDR_W-1:0] wr_ptr_o,
  output logic [ADDR_W-1:0] rd_ptr_o,
  output logic [ADDR_W:0]   count_o,
  output logic              valid_o,
  output logic              ready_o,
  output logic              overflow_o,
  output logic              underflow_o
);
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] READY_MAX = (ADDR_W+1)'(DEPTH - 2);

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ready_q, overflow_q, underflow_q;
  logic              full, empty, wr_acc, rd_acc;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  // A read never makes room for a same-cycle write; freed space is usable next cycle.
  assign wr_acc = w_en_i && !full;
  assign rd_acc = r_en_i && !empty;

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc)
      count_d = count_q + (ADDR_W+1)'(1);
    else if (rd_acc && !wr_acc)
      count_d = count_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (rd_acc) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
      // Keeping one spare slot absorbs the write already in flight when ready drops.
      ready_q <= (count_d <= READY_MAX);
      if (w_en_i && full)  overflow_q  <= 1'b1;
      if (r_en_i && empty) underflow_q <= 1'b1;
    end
  end

  assign wr_accept_o = wr_acc;
  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;
  assign valid_o     = !empty;
  assign ready_o     = ready_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
endmodule

// File: rtl/fifo_out_buffer.sv
// rtl/fifo_out_buffer.sv - FWFT result FIFO between the ALU output control unit and the host
module fifo_out_buffer
  import alu_pkg::*;
#(
  parameter int FIFO_OUT_WIDTH = alu_pkg::FIFO_OUT_WIDTH,
  parameter int DEPTH          = alu_pkg::FIFO_OUT_DEPTH,
  parameter int ADDR_W         = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_en_out,
  input  logic [FIFO_OUT_WIDTH-1:0] fifo_res,
  output logic                      ready_f_res,
  input  logic                      r_en,
  output logic [FIFO_OUT_WIDTH-1:0] dout,
  output logic                      valid_out,
  output logic [ADDR_W:0]           count,
  output logic                      overflow,
  output logic                      underflow
);
  logic [FIFO_OUT_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]         wr_ptr, rd_ptr;
  logic                      wr_accept;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ptr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .w_en_i     (w_en_out),
    .r_en_i     (r_en),
    .wr_accept_o(wr_accept),
    .wr_ptr_o   (wr_ptr),
    .rd_ptr_o   (rd_ptr),
    .count_o    (count),
    .valid_o    (valid_out),
    .ready_o    (ready_f_res),
    .overflow_o (overflow),
    .underflow_o(underflow)
  );

  // Storage is deliberately not reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr] <= fifo_res;
  end

  assign dout = mem_q[rd_ptr];
endmodule
